player_ship_ctrl: RTL and testbench

PLAYER_SHIP_CTRL -- requirements
Module: player_ship_ctrl

---
 rtl/player_ship_ctrl.sv | 174 +++++++++++++++++
 tb/tb_player_ship_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/player_ship_ctrl.sv
// Player ship controller: button-driven horizontal movement with auto-repeat,
// plus a single-shot fire handshake with a frame-based cooldown.
module player_ship_ctrl #(
    parameter logic [9:0] X_MIN       = 10'd8,
    parameter logic [9:0] X_MAX       = 10'd600,
    parameter logic [9:0] X_INIT      = 10'd300,
    parameter logic [9:0] STEP        = 10'd4,
    parameter logic [5:0] REPEAT_DLY  = 6'd20,
    parameter logic [5:0] REPEAT_RATE = 6'd4,
    parameter logic [5:0] COOLDOWN    = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       left_clean,
    input  logic       right_clean,
    input  logic       left_single,
    input  logic       right_single,
    input  logic       fire_single,
    input  logic       fire_ack,
    output logic [9:0] ship_x,
    output logic       fire_req,
    output logic [9:0] fire_x,
    output logic       cooldown_active
);

    typedef enum logic [1:0] {M_IDLE, M_DLY, M_RPT} move_state_t;
    typedef enum logic [1:0] {F_READY, F_REQ, F_COOL} fire_state_t;

    move_state_t move_q, move_d;
    fire_state_t fire_q, fire_d;
    logic        dir_q, dir_d;
    logic [5:0]  mcnt_q, mcnt_d;
    logic [5:0]  fcnt_q, fcnt_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  fx_q, fx_d;
    logic        req_q, req_d;
    logic        cool_q, cool_d;

    logic        do_move;
    logic        move_dir;
    logic        held;
    logic [5:0]  mcnt_inc;
    logic [10:0] x_right;
    logic [10:0] x_left_lim;

    assign held       = dir_q ? right_clean : left_clean;
    assign mcnt_inc   = mcnt_q + 6'd1;
    // 11-bit sums so a step past either edge saturates instead of wrapping
    assign x_right    = {1'b0, x_q} + {1'b0, STEP};
    assign x_left_lim = {1'b0, X_MIN} + {1'b0, STEP};

    always_comb begin
        move_d   = move_q;
        dir_d    = dir_q;
        mcnt_d   = mcnt_q;
        do_move  = 1'b0;
        move_dir = dir_q;
        if (left_single ^ right_single) begin
            dir_d    = right_single;
            move_dir = right_single;
            do_move  = 1'b1;
            mcnt_d   = 6'd0;
            move_d   = M_DLY;
        end else if (left_single && right_single) begin
            move_d = M_IDLE;
        end else if (move_q != M_IDLE) begin
            // button release wins over a coincident frame tick
            if (!held) begin
                move_d = M_IDLE;
            end else if (frame_tick) begin
                if (move_q == M_DLY) begin
                    if (mcnt_inc == REPEAT_DLY) begin
                        move_d = M_RPT;
                        mcnt_d = 6'd0;
                    end else begin
                        mcnt_d = mcnt_inc;
                    end
                end else if (mcnt_inc == REPEAT_RATE) begin
                    do_move = 1'b1;
                    mcnt_d  = 6'd0;
                end else begin
                    mcnt_d = mcnt_inc;
                end
            end
        end
    end

    always_comb begin
        x_d = x_q;
        if (do_move) begin
            if (move_dir) begin
                x_d = (x_right > {1'b0, X_MAX}) ? X_MAX : x_right[9:0];
            end else begin
                x_d = ({1'b0, x_q} < x_left_lim) ? X_MIN : (x_q - STEP);
            end
        end
    end

    always_comb begin
        fire_d = fire_q;
        fcnt_d = fcnt_q;
        fx_d   = fx_q;
        req_d  = req_q;
        cool_d = cool_q;
        case (fire_q)
            F_READY: begin
                if (fire_single) begin
                    fx_d   = x_q;
                    req_d  = 1'b1;
                    fire_d = F_REQ;
                end
            end
            F_REQ: begin
                if (fire_ack) begin
                    req_d = 1'b0;
                    if (COOLDOWN == 6'd0) begin
                        fire_d = F_READY;
                    end else begin
                        fire_d = F_COOL;
                        cool_d = 1'b1;
                        fcnt_d = COOLDOWN;
                    end
                end
            end
            F_COOL: begin
                if (frame_tick) begin
                    if (fcnt_q <= 6'd1) begin
                        fcnt_d = 6'd0;
                        fire_d = F_READY;
                        cool_d = 1'b0;
                    end else begin
                        fcnt_d = fcnt_q - 6'd1;
                    end
                end
            end
            default: begin
                fire_d = F_READY;
                req_d  = 1'b0;
                cool_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            move_q <= M_IDLE;
            dir_q  <= 1'b0;
            mcnt_q <= 6'd0;
            x_q    <= X_INIT;
            fire_q <= F_READY;
            fcnt_q <= 6'd0;
            fx_q   <= 10'd0;
            req_q  <= 1'b0;
            cool_q <= 1'b0;
        end else begin
            move_q <= move_d;
            dir_q  <= dir_d;
            mcnt_q <= mcnt_d;
            x_q    <= x_d;
            fire_q <= fire_d;
            fcnt_q <= fcnt_d;
            fx_q   <= fx_d;
            req_q  <= req_d;
            cool_q <= cool_d;
        end
    end

    assign ship_x          = x_q;
    assign fire_req        = req_q;
    assign fire_x          = fx_q;
    assign cooldown_active = cool_q;

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Bench for player_ship_ctrl: directed vector table, corner-case sequences,
// then random stimulus against a hold-time based reference model.
module tb_player_ship_ctrl;

    localparam int X_MIN = 8, X_MAX = 600, X_INIT = 300, STEP = 4;
    localparam int RDLY = 20, RRATE = 4, CD = 30;

    logic       clk = 1'b0;
    logic       rst, frame_tick, left_clean, right_clean;
    logic       left_single, right_single, fire_single, fire_ack;
    logic [9:0] ship_x, fire_x;
    logic       fire_req, cooldown_active;

    int n_tests = 0;
    int n_fail  = 0;

    player_ship_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .left_clean(left_clean), .right_clean(right_clean),
        .left_single(left_single), .right_single(right_single),
        .fire_single(fire_single), .fire_ack(fire_ack),
        .ship_x(ship_x), .fire_req(fire_req), .fire_x(fire_x),
        .cooldown_active(cooldown_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit r, t, lc, rc, ls, rs, fs, ak;
    } in_t;

    typedef struct {
        in_t in;
        int  x;
        bit  req;
        int  fx;
        bit  cool;
    } vec_t;

    // Model: ship position, how many ticks the move button has been held since
    // its press, and the remaining cooldown ticks.
    int m_x, m_fx, m_held, m_cd;
    bit m_active, m_dir, m_req, m_cool;

    function automatic in_t mk(bit r, bit t, bit lc, bit rc, bit ls, bit rs, bit fs, bit ak);
        in_t v;
        v = '{r: r, t: t, lc: lc, rc: rc, ls: ls, rs: rs, fs: fs, ak: ak};
        return v;
    endfunction

    function automatic int moved(int x, bit right);
        int n;
        n = right ? x + STEP : x - STEP;
        if (n > X_MAX) n = X_MAX;
        if (n < X_MIN) n = X_MIN;
        return n;
    endfunction

    task automatic model_step(input in_t v);
        int old_x;
        old_x = m_x;
        if (v.r) begin
            m_x = X_INIT; m_fx = 0; m_held = 0; m_cd = 0;
            m_active = 0; m_dir = 0; m_req = 0; m_cool = 0;
            return;
        end
        if (v.ls != v.rs) begin
            m_dir = v.rs; m_x = moved(m_x, v.rs); m_active = 1; m_held = 0;
        end else if (v.ls && v.rs) begin
            m_active = 0;
        end else if (m_active) begin
            if (!(m_dir ? v.rc : v.lc)) begin
                m_active = 0;
            end else if (v.t) begin
                m_held++;
                if (m_held > RDLY && ((m_held - RDLY) % RRATE) == 0)
                    m_x = moved(m_x, m_dir);
            end
        end
        if (!m_req && !m_cool) begin
            if (v.fs) begin
                m_fx = old_x; m_req = 1;
            end
        end else if (m_req) begin
            if (v.ak) begin
                m_req = 0; m_cd = CD; m_cool = (CD > 0);
            end
        end else if (v.t) begin
            m_cd--;
            if (m_cd == 0) m_cool = 0;
        end
    endtask

    task automatic cyc(input in_t v);
        rst = v.r; frame_tick = v.t; left_clean = v.lc; right_clean = v.rc;
        left_single = v.ls; right_single = v.rs; fire_single = v.fs; fire_ack = v.ak;
        model_step(v);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".ship_x"}, int'(ship_x), m_x);
        chk({tag, ".fire_req"}, int'(fire_req), int'(m_req));
        chk({tag, ".fire_x"}, int'(fire_x), m_fx);
        chk({tag, ".cooldown"}, int'(cooldown_active), int'(m_cool));
    endtask

    vec_t tbl[12];
    in_t  z;

    initial begin
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0; frame_tick = 0; left_clean = 0; right_clean = 0;
        left_single = 0; right_single = 0; fire_single = 0; fire_ack = 0;

        //                r  t  lc rc ls rs fs ak        x   req fx  cool
        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0), 300, 0, 0,   0};
        tbl[1]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0), 296, 0, 0,   0};
        tbl[2]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0), 296, 0, 0,   0};
        tbl[3]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0), 296, 0, 0,   0};
        tbl[4]  = '{mk(0, 0, 0, 0, 1, 1, 0, 0), 296, 0, 0,   0};
        tbl[5]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0), 300, 0, 0,   0};
        tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0), 300, 1, 300, 0};
        tbl[7]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0), 304, 1, 300, 0};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1), 304, 0, 300, 1};
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0), 304, 0, 300, 1};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1), 304, 0, 300, 1};
        tbl[11] = '{mk(1, 0, 0, 0, 0, 0, 0, 0), 300, 0, 0,   0};

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].in);
            chk($sformatf("vec%0d.ship_x", i), int'(ship_x), tbl[i].x);
            chk($sformatf("vec%0d.fire_req", i), int'(fire_req), int'(tbl[i].req));
            chk($sformatf("vec%0d.fire_x", i), int'(fire_x), tbl[i].fx);
            chk($sformatf("vec%0d.cooldown", i), int'(cooldown_active), int'(tbl[i].cool));
        end

        // Auto-repeat timing; a release coincident with a tick must not move
        cyc(mk(0, 0, 0, 1, 0, 1, 0, 0));
        chk("rpt.first", int'(ship_x), 304);
        for (int t = 1; t <= 31; t++) begin
            cyc(mk(0, 1, 0, 1, 0, 0, 0, 0));
            chk($sformatf("rpt.tick%0d", t), int'(ship_x), (t >= 28) ? 312 : (t >= 24) ? 308 : 304);
            cyc(mk(0, 0, 0, 1, 0, 0, 0, 0));
        end
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 0));
        chk("rpt.release", int'(ship_x), 312);
        for (int t = 0; t < 8; t++) cyc(mk(0, 1, 0, 1, 0, 0, 0, 0));
        chk("rpt.idle", int'(ship_x), 312);

        // Saturation at X_MIN
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 72; i++) cyc(mk(0, 0, 0, 0, 1, 0, 0, 0));
        chk("sat.left12", int'(ship_x), 12);
        cyc(mk(0, 0, 1, 0, 1, 0, 0, 0));
        chk("sat.left8", int'(ship_x), 8);
        for (int t = 0; t < 40; t++) cyc(mk(0, 1, 1, 0, 0, 0, 0, 0));
        chk("sat.left_hold", int'(ship_x), 8);

        // Saturation at X_MAX
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 75; i++) cyc(mk(0, 0, 0, 0, 0, 1, 0, 0));
        chk("sat.right600", int'(ship_x), 600);
        cyc(mk(0, 0, 0, 1, 0, 1, 0, 0));
        for (int t = 0; t < 40; t++) cyc(mk(0, 1, 0, 1, 0, 0, 0, 0));
        chk("sat.right_hold", int'(ship_x), 600);

        // Fire, handshake, cooldown
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0));
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0));
        chk("fire.req", int'(fire_req), 1);
        chk("fire.x", int'(fire_x), 300);
        for (int i = 0; i < 5; i++) cyc(z);
        chk("fire.hold", int'(fire_req), 1);
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1));
        chk("fire.ack_req", int'(fire_req), 0);
        chk("fire.ack_cool", int'(cooldown_active), 1);
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0));
        chk("fire.ignored", int'(fire_req), 0);
        for (int t = 0; t < 29; t++) cyc(mk(0, 1, 0, 0, 0, 0, 0, 0));
        chk("cool.tick29", int'(cooldown_active), 1);
        cyc(mk(0, 1, 0, 0, 0, 0, 0, 0));
        chk("cool.tick30", int'(cooldown_active), 0);
        cyc(mk(0, 0, 0, 0, 0, 1, 1, 0));
        chk("fire2.req", int'(fire_req), 1);
        chk("fire2.x", int'(fire_x), 300);
        chk("fire2.ship_x", int'(ship_x), 304);

        // Reset during a pending request at x=500
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 50; i++) cyc(mk(0, 0, 0, 0, 0, 1, 0, 0));
        cyc(mk(0, 0, 0, 0, 0, 0, 1, 0));
        chk("rstreq.x", int'(fire_x), 500);
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0));
        chk_model("rstreq.reset");
        chk("rstreq.fire_req", int'(fire_req), 0);
        cyc(mk(0, 0, 0, 0, 0, 0, 0, 1));
        chk("rstreq.late_ack_req", int'(fire_req), 0);
        chk("rstreq.late_ack_cool", int'(cooldown_active), 0);

        // Random stimulus against the model
        begin
            bit lc, rc;
            lc = 0; rc = 0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 19) == 0) lc = ~lc;
                if ($urandom_range(0, 19) == 0) rc = ~rc;
                cyc(mk($urandom_range(0, 599) == 0, $urandom_range(0, 2) == 0, lc, rc,
                       $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0));
                chk_model("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
